// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select stage.
//   ld_size_t : load size encoding as carried on in_ld_size (2'b11 behaves as full width)
//   state_t   : occupancy of the output register / skid buffer pair
//   SRC_*     : conventional source indices used by the pipeline
package wb_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_PC8  = 2;
  localparam int SRC_HILO = 3;

endpackage

// File: rtl/wb_select_stage_if.sv
// Handshake bundle between the MEM stage, the writeback select stage and the
// register file.
//   master : upstream/downstream environment (drives in_*, flush, out_ready)
//   slave  : the writeback stage itself (drives in_ready and out_*)
// Parameters must match those of the wb_select_stage instance it connects to.
interface wb_select_stage_if #(
  parameter int DW   = 32,
  parameter int NSRC = 4,
  parameter int RAW  = 5
);
  localparam int SW = $clog2(NSRC);
  localparam int BW = $clog2(DW/8);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [SW-1:0]       in_sel;
  logic [NSRC*DW-1:0]  in_src;
  logic [1:0]          in_ld_size;
  logic                in_ld_signed;
  logic [BW-1:0]       in_addr_lo;
  logic [RAW-1:0]      in_rd;
  logic                in_we;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [RAW-1:0]      out_rd;
  logic                out_we;

  modport master (
    output flush, in_valid, in_sel, in_src, in_ld_size, in_ld_signed,
           in_addr_lo, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we
  );

  modport slave (
    input  flush, in_valid, in_sel, in_src, in_ld_size, in_ld_signed,
           in_addr_lo, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we
  );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load-data alignment.
//   data      : full memory word
//   size      : LD_B / LD_H / LD_W (2'b11 treated as full width)
//   is_signed : sign-extend narrow loads when set, zero-extend otherwise
//   addr_lo   : byte offset of the load within the word
//   aligned   : extracted and extended result
// Half-word loads ignore addr_lo[0]; misaligned halves are not split.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int BW = $clog2(DW/8)
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    size,
  input  logic          is_signed,
  input  logic [BW-1:0] addr_lo,
  output logic [DW-1:0] aligned
);
  localparam int NB = DW/8;
  localparam int NH = DW/16;

  logic [7:0]  byte_arr [NB];
  logic [15:0] half_arr [NH];
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign byte_arr[gi] = data[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < NH; gi++) begin : g_half
      assign half_arr[gi] = data[gi*16 +: 16];
    end
  endgenerate

  assign byte_lane = byte_arr[addr_lo];
  assign half_lane = half_arr[addr_lo[BW-1:1]];

  always_comb begin
    aligned = data;
    case (size)
      LD_B:    aligned = {{(DW-8){is_signed & byte_lane[7]}}, byte_lane};
      LD_H:    aligned = {{(DW-16){is_signed & half_lane[15]}}, half_lane};
      default: aligned = data;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB writeback select stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : wb_select_stage_if.slave
//                in_*  : entry offered by the MEM stage (valid/ready)
//                out_* : registered result toward the register file (valid/ready)
//                flush : synchronous discard of every held entry
// The result is formed on accept (source select, load alignment, write-enable
// qualification) and held in an output register backed by one skid entry, so
// in_ready can be a flop that never depends on out_ready in the same cycle.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NSRC    = 4,
  parameter int RAW     = 5,
  parameter int MEM_IDX = SRC_MEM
) (
  input logic               clk,
  input logic               rst_n,
  wb_select_stage_if.slave  bus
);
  localparam int SW = $clog2(NSRC);

  // ---------------------------------------------------------------- datapath
  logic [DW-1:0]   src_arr [NSRC];
  logic [NSRC-1:0] sel_hit;
  logic [DW-1:0]   raw_data;
  logic [DW-1:0]   mem_data;
  logic [DW-1:0]   new_data;
  logic            new_we;
  logic            sel_in_range;
  logic            sel_is_mem;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = bus.in_src[gi*DW +: DW];
      assign sel_hit[gi] = (bus.in_sel == SW'(gi));
    end
  endgenerate

  // One-hot AND-OR mux; an out-of-range select hits nothing and yields zero.
  always_comb begin
    raw_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      raw_data = raw_data | (src_arr[k] & {DW{sel_hit[k]}});
    end
  end

  assign sel_in_range = |sel_hit;
  assign sel_is_mem   = sel_hit[MEM_IDX];

  wb_load_align #(.DW(DW)) u_align (
    .data      (src_arr[MEM_IDX]),
    .size      (bus.in_ld_size),
    .is_signed (bus.in_ld_signed),
    .addr_lo   (bus.in_addr_lo),
    .aligned   (mem_data)
  );

  assign new_data = !sel_in_range ? '0 : (sel_is_mem ? mem_data : raw_data);
  // Register 0 is hardwired; never issue a write to it.
  assign new_we   = bus.in_we && (bus.in_rd != '0) && sel_in_range;

  // ------------------------------------------------------------- control FSM
  state_t state_reg, state_next;
  logic   in_ready_reg;
  logic   out_valid_reg;
  logic   accept;
  logic   consume;
  logic   load_out_new;
  logic   load_out_skid;
  logic   load_skid;

  assign accept  = bus.in_valid && in_ready_reg;
  assign consume = out_valid_reg && bus.out_ready;

  // State register; ready/valid are registered copies of the next state so
  // the handshake outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != ST_TWO);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_next = ST_TWO;
          else if (!accept && consume) state_next = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Datapath load enables; nothing is captured in a flush cycle.
  always_comb begin
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (!bus.flush) begin
      case (state_reg)
        ST_EMPTY: load_out_new = accept;
        ST_ONE: begin
          load_out_new = accept && consume;
          load_skid    = accept && !consume;
        end
        ST_TWO:   load_out_skid = consume;
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------- output / skid regs
  logic [DW-1:0]  out_data_reg,  skid_data_reg;
  logic [RAW-1:0] out_rd_reg,    skid_rd_reg;
  logic           out_we_reg,    skid_we_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_rd_reg    <= '0;
      out_we_reg    <= 1'b0;
      skid_data_reg <= '0;
      skid_rd_reg   <= '0;
      skid_we_reg   <= 1'b0;
    end else begin
      if (load_out_new) begin
        out_data_reg <= new_data;
        out_rd_reg   <= bus.in_rd;
        out_we_reg   <= new_we;
      end else if (load_out_skid) begin
        out_data_reg <= skid_data_reg;
        out_rd_reg   <= skid_rd_reg;
        out_we_reg   <= skid_we_reg;
      end
      if (load_skid) begin
        skid_data_reg <= new_data;
        skid_rd_reg   <= bus.in_rd;
        skid_we_reg   <= new_we;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_rd    = out_rd_reg;
  assign bus.out_we    = out_we_reg;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage (DW=32, NSRC=6 so select 6/7 is out of range).
// Expected results are queued when an entry is accepted and compared when the
// register file consumes it.
module tb_wb_select_stage;
  import wb_pkg::*;

  localparam int DW   = 32;
  localparam int NSRC = 6;
  localparam int RAW  = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_select_stage_if #(.DW(DW), .NSRC(NSRC), .RAW(RAW)) bus ();

  wb_select_stage #(.DW(DW), .NSRC(NSRC), .RAW(RAW), .MEM_IDX(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [RAW-1:0] rd;
    logic           we;
  } exp_t;

  exp_t           q[$];
  int             n_checks = 0;
  int             n_pass   = 0;
  logic [DW-1:0]  p_data;
  logic [RAW-1:0] p_rd;
  logic           p_we;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: pop on consume, then push on accept (or discard on flush).
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", bus.out_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("consume data=%08h rd=%0d we=%0b (exp %08h/%0d/%0b)",
                   bus.out_data, bus.out_rd, bus.out_we, e.data, e.rd, e.we);
          check("out_data", bus.out_data, e.data);
          check("out_rd",   bus.out_rd,   e.rd);
          check("out_we",   bus.out_we,   e.we);
        end
      end
      if (bus.flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back('{data: p_data, rd: p_rd, we: p_we});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] sel, input logic [1:0] size, input logic sgn,
                         input logic [1:0] off, input logic [4:0] rd, input logic we,
                         input logic [31:0] exp_data, input logic exp_we);
    bus.in_sel       = sel;
    bus.in_ld_size   = size;
    bus.in_ld_signed = sgn;
    bus.in_addr_lo   = off;
    bus.in_rd        = rd;
    bus.in_we        = we;
    bus.in_valid     = 1'b1;
    p_data = exp_data;
    p_rd   = rd;
    p_we   = exp_we;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic send(input logic [2:0] sel, input logic [1:0] size, input logic sgn,
                      input logic [1:0] off, input logic [4:0] rd, input logic we,
                      input logic [31:0] exp_data, input logic exp_we);
    present(sel, size, sgn, off, rd, we, exp_data, exp_we);
    wait_accept();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.in_sel       = '0;
    bus.in_ld_size   = 2'b10;
    bus.in_ld_signed = 1'b0;
    bus.in_addr_lo   = '0;
    bus.in_rd        = '0;
    bus.in_we        = 1'b0;
    p_data = '0; p_rd = '0; p_we = 1'b0;
    bus.in_src[0*32 +: 32] = 32'h11111111;
    bus.in_src[1*32 +: 32] = 32'h22222222;
    bus.in_src[2*32 +: 32] = 32'h33333333;
    bus.in_src[3*32 +: 32] = 32'h44444444;
    bus.in_src[4*32 +: 32] = 32'h55555555;
    bus.in_src[5*32 +: 32] = 32'h66666666;

    // Reset state
    step();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  32'h0);
    check("rst_out_rd",    bus.out_rd,    5'd0);
    check("rst_out_we",    bus.out_we,    1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Source select, one per cycle, result one cycle after accept
    send(3'd0, LD_W, 1'b0, 2'd0, 5'd1, 1'b1, 32'h11111111, 1'b1);
    check("latency_valid", bus.out_valid, 1'b1);
    check("latency_data",  bus.out_data,  32'h11111111);
    send(3'd1, LD_W, 1'b0, 2'd0, 5'd2, 1'b1, 32'h22222222, 1'b1);
    check("throughput_ready", bus.in_ready, 1'b1);
    send(3'd2, LD_W, 1'b0, 2'd0, 5'd3, 1'b1, 32'h33333333, 1'b1);
    send(3'd3, LD_W, 1'b0, 2'd0, 5'd4, 1'b1, 32'h44444444, 1'b1);
    idle();
    step(); step();

    // Load alignment on the memory source
    bus.in_src[1*32 +: 32] = 32'h80FF7F01;
    send(3'd1, LD_B,  1'b1, 2'd0, 5'd5, 1'b1, 32'h00000001, 1'b1);
    send(3'd1, LD_B,  1'b1, 2'd1, 5'd5, 1'b1, 32'h0000007F, 1'b1);
    send(3'd1, LD_B,  1'b1, 2'd2, 5'd5, 1'b1, 32'hFFFFFFFF, 1'b1);
    send(3'd1, LD_B,  1'b1, 2'd3, 5'd5, 1'b1, 32'hFFFFFF80, 1'b1);
    send(3'd1, LD_B,  1'b0, 2'd3, 5'd5, 1'b1, 32'h00000080, 1'b1);
    send(3'd1, LD_H,  1'b0, 2'd2, 5'd5, 1'b1, 32'h000080FF, 1'b1);
    send(3'd1, LD_H,  1'b0, 2'd3, 5'd5, 1'b1, 32'h000080FF, 1'b1);
    send(3'd1, LD_H,  1'b1, 2'd2, 5'd5, 1'b1, 32'hFFFF80FF, 1'b1);
    send(3'd1, LD_H,  1'b1, 2'd0, 5'd5, 1'b1, 32'h00007F01, 1'b1);
    send(3'd1, LD_W,  1'b1, 2'd2, 5'd5, 1'b1, 32'h80FF7F01, 1'b1);
    send(3'd1, 2'b11, 1'b1, 2'd1, 5'd5, 1'b1, 32'h80FF7F01, 1'b1);
    send(3'd0, LD_B,  1'b1, 2'd3, 5'd5, 1'b1, 32'h11111111, 1'b1);
    idle();
    step(); step();

    // Back-pressure: two entries fill the stage, the third waits
    bus.out_ready = 1'b0;
    send(3'd0, LD_W, 1'b0, 2'd0, 5'd6, 1'b1, 32'h11111111, 1'b1);
    send(3'd2, LD_W, 1'b0, 2'd0, 5'd7, 1'b1, 32'h33333333, 1'b1);
    check("bp_in_ready_low", bus.in_ready,  1'b0);
    check("bp_out_valid",    bus.out_valid, 1'b1);
    present(3'd3, LD_W, 1'b0, 2'd0, 5'd8, 1'b1, 32'h44444444, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_ready", bus.in_ready, 1'b0);
      check("bp_out_stable", bus.out_data, 32'h11111111);
    end
    bus.out_ready = 1'b1;
    wait_accept();
    send(3'd4, LD_W, 1'b0, 2'd0, 5'd9,  1'b1, 32'h55555555, 1'b1);
    send(3'd5, LD_W, 1'b0, 2'd0, 5'd10, 1'b1, 32'h66666666, 1'b1);
    idle();
    step(); step(); step();
    check("bp_drained", q.size(), 0);

    // Flush from TWO with an entry offered
    bus.out_ready = 1'b0;
    send(3'd0, LD_W, 1'b0, 2'd0, 5'd11, 1'b1, 32'h11111111, 1'b1);
    send(3'd2, LD_W, 1'b0, 2'd0, 5'd12, 1'b1, 32'h33333333, 1'b1);
    present(3'd3, LD_W, 1'b0, 2'd0, 5'd13, 1'b1, 32'h44444444, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    check("flush_two_valid", bus.out_valid, 1'b0);
    check("flush_two_ready", bus.in_ready,  1'b1);
    bus.out_ready = 1'b1;
    step(); step(); step();

    // Flush from ONE while the offered entry would otherwise be accepted
    bus.out_ready = 1'b0;
    send(3'd4, LD_W, 1'b0, 2'd0, 5'd14, 1'b1, 32'h55555555, 1'b1);
    present(3'd5, LD_W, 1'b0, 2'd0, 5'd15, 1'b1, 32'h66666666, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    check("flush_one_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    step(); step(); step();

    // Flush coinciding with a consume: the consumed entry is delivered
    send(3'd3, LD_W, 1'b0, 2'd0, 5'd16, 1'b1, 32'h44444444, 1'b1);
    present(3'd2, LD_W, 1'b0, 2'd0, 5'd17, 1'b1, 32'h33333333, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    check("flush_consume_valid", bus.out_valid, 1'b0);
    step(); step();
    check("flush_drained", q.size(), 0);

    // Register 0, out-of-range select, write disabled
    send(3'd0, LD_W, 1'b0, 2'd0, 5'd0,  1'b1, 32'h11111111, 1'b0);
    send(3'd7, LD_W, 1'b0, 2'd0, 5'd3,  1'b1, 32'h00000000, 1'b0);
    send(3'd6, LD_B, 1'b1, 2'd2, 5'd3,  1'b1, 32'h00000000, 1'b0);
    send(3'd3, LD_W, 1'b0, 2'd0, 5'd3,  1'b0, 32'h44444444, 1'b0);
    send(3'd5, LD_W, 1'b0, 2'd0, 5'd31, 1'b1, 32'h66666666, 1'b1);
    idle();
    step(); step();

    // Asynchronous reset mid-stream with back-pressure
    bus.out_ready = 1'b0;
    send(3'd0, LD_W, 1'b0, 2'd0, 5'd18, 1'b1, 32'h11111111, 1'b1);
    send(3'd2, LD_W, 1'b0, 2'd0, 5'd19, 1'b1, 32'h33333333, 1'b1);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data",  bus.out_data,  32'h0);
    check("arst_out_rd",    bus.out_rd,    5'd0);
    check("arst_out_we",    bus.out_we,    1'b0);
    check("arst_in_ready",  bus.in_ready,  1'b1);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(3'd2, LD_W, 1'b0, 2'd0, 5'd4, 1'b1, 32'h33333333, 1'b1);
    check("arst_first_accept", bus.out_valid, 1'b1);
    idle();
    step(); step();
    check("final_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
